// File: rtl/bus_sync_sender_pkg.sv
// Shared definitions for the bus synchronizer sender: FSM encoding and
// default sizing constants used by the sender and its testbench.
package bus_sync_sender_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    REQ      = 2'b01,
    WAIT_LOW = 2'b10
  } state_t;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_ACK_STAGES = 2;
  localparam int DEF_TIMEOUT    = 255;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop level synchronizer for a single asynchronous bit. Kept generic
// so the destination side can reuse it for the request level.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] sync_q;

  // Shift the async level through STAGES flops; the last flop is the clean copy.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
    end
  end

  assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/bus_sync_sender.sv
// Source side of a 4-phase bus synchronizer. A word is held stable on
// unsync_bus while bus_enable is raised; the destination samples it after
// synchronizing bus_enable and answers with ack_async. A request that gets no
// acknowledge within TIMEOUT cycles is abandoned and flagged in timeout_err.
module bus_sync_sender
  import bus_sync_sender_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ACK_STAGES = DEF_ACK_STAGES,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ack_async,
  input  logic             err_clr,
  output logic [WIDTH-1:0] unsync_bus,
  output logic             bus_enable,
  output logic             done,
  output logic             timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  state_t          state;
  logic            ack_sync;
  logic [CW-1:0]   req_cnt;
  logic            timed_out;

  bit_sync #(
    .STAGES(ACK_STAGES)
  ) u_ack_sync (
    .CLK     (CLK),
    .RST     (RST),
    .async_in(ack_async),
    .sync_out(ack_sync)
  );

  // A stale acknowledge from the previous transfer must drain before a new word is taken.
  assign in_ready = (state == IDLE) && !ack_sync;

  // Handshake FSM with registered data, request level, done pulse and sticky error.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      unsync_bus  <= '0;
      bus_enable  <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      req_cnt     <= '0;
      timed_out   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (err_clr) begin
        timeout_err <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (in_valid && !ack_sync) begin
            unsync_bus <= in_data;
            bus_enable <= 1'b1;
            req_cnt    <= '0;
            timed_out  <= 1'b0;
            state      <= REQ;
          end
        end
        REQ: begin
          if (ack_sync) begin
            bus_enable <= 1'b0;
            state      <= WAIT_LOW;
          end else if (req_cnt == CNT_LAST) begin
            bus_enable  <= 1'b0;
            timeout_err <= 1'b1;
            timed_out   <= 1'b1;
            state       <= WAIT_LOW;
          end else if (req_cnt != CNT_MAX) begin
            req_cnt <= req_cnt + 1'b1;
          end
        end
        WAIT_LOW: begin
          if (!ack_sync) begin
            done  <= !timed_out;
            state <= IDLE;
          end
        end
        default: begin
          bus_enable <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_sync_sender.sv
// Self-checking bench for bus_sync_sender: table-driven echo transfers plus
// hand-written sequences for back-to-back words, timeout, stale ack and reset.
module tb_bus_sync_sender;

  localparam int WIDTH      = 8;
  localparam int ACK_STAGES = 2;
  localparam int TIMEOUT    = 8;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             ack_async;
  logic             err_clr = 1'b0;
  logic [WIDTH-1:0] unsync_bus;
  logic             bus_enable;
  logic             done;
  logic             timeout_err;

  logic echo_mode  = 1'b0;
  logic forced_ack = 1'b0;

  int n_checks   = 0;
  int n_fail     = 0;
  int done_count = 0;
  int high_cnt   = 0;
  int last_high  = 0;
  logic prev_be  = 1'b0;
  logic [WIDTH-1:0] sb_q[$];

  typedef struct {
    logic [WIDTH-1:0] data;
    int               exp_high;
    int               exp_done;
  } vec_t;

  vec_t vecs[4];

  // Destination model: either echo the request level or drive a forced level.
  assign ack_async = echo_mode ? bus_enable : forced_ack;

  bus_sync_sender #(
    .WIDTH     (WIDTH),
    .ACK_STAGES(ACK_STAGES),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ack_async  (ack_async),
    .err_clr    (err_clr),
    .unsync_bus (unsync_bus),
    .bus_enable (bus_enable),
    .done       (done),
    .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  // Offer a word and record it as expected on the next bus_enable rise.
  task automatic applyStimulus(input logic [WIDTH-1:0] data);
    sb_q.push_back(data);
    in_data  = data;
    in_valid = 1'b1;
  endtask

  task automatic waitLevel(input logic level, input string name);
    for (int i = 0; i < 40; i++) begin
      if (bus_enable === level) return;
      tick(1);
    end
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: bus_enable never reached %0b, got %0b", name, level, bus_enable);
  endtask

  task automatic waitDone(input string name);
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (done === 1'b1) return;
    end
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: done never pulsed, got %0b", name, done);
  endtask

  // Monitor: count done pulses, measure request width, and score captured words.
  always @(negedge CLK) begin
    logic [WIDTH-1:0] exp_word;
    if (done === 1'b1) done_count++;
    if (bus_enable === 1'b1) begin
      high_cnt++;
    end else if (prev_be) begin
      last_high = high_cnt;
      high_cnt  = 0;
    end
    if (bus_enable === 1'b1 && !prev_be) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL sb_unexpected_capture: got %0h, expected no capture", unsync_bus);
      end else begin
        exp_word = sb_q.pop_front();
        checkOutput("sb_capture", 32'(unsync_bus), 32'(exp_word));
      end
    end
    prev_be = (bus_enable === 1'b1);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int d0;
    vecs[0] = '{data: 8'hA5, exp_high: ACK_STAGES + 1, exp_done: 1};
    vecs[1] = '{data: 8'hFF, exp_high: ACK_STAGES + 1, exp_done: 1};
    vecs[2] = '{data: 8'h00, exp_high: ACK_STAGES + 1, exp_done: 1};
    vecs[3] = '{data: 8'h3C, exp_high: ACK_STAGES + 1, exp_done: 1};

    // Reset state
    tick(3);
    checkOutput("rst_bus_enable", 32'(bus_enable), 32'(0));
    checkOutput("rst_unsync_bus", 32'(unsync_bus), 32'(0));
    checkOutput("rst_done", 32'(done), 32'(0));
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'(0));
    @(negedge CLK);
    RST = 1'b1;
    tick(1);
    checkOutput("rst_in_ready", 32'(in_ready), 32'(1));

    // Table-driven echo transfers
    echo_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d0 = done_count;
      applyStimulus(vecs[i].data);
      waitLevel(1'b1, "vec_rise");
      in_valid = 1'b0;
      checkOutput("vec_in_ready_busy", 32'(in_ready), 32'(0));
      checkOutput("vec_bus_at_capture", 32'(unsync_bus), 32'(vecs[i].data));
      waitDone("vec_done");
      checkOutput("vec_high_cycles", 32'(last_high), 32'(vecs[i].exp_high));
      checkOutput("vec_bus_hold", 32'(unsync_bus), 32'(vecs[i].data));
      tick(1);
      checkOutput("vec_in_ready_after", 32'(in_ready), 32'(1));
      tick(3);
      checkOutput("vec_done_pulses", 32'(done_count - d0), 32'(vecs[i].exp_done));
    end

    // Back-to-back words with in_valid held high
    d0 = done_count;
    applyStimulus(8'h01);
    waitLevel(1'b1, "b2b_first_rise");
    applyStimulus(8'h02);
    waitLevel(1'b0, "b2b_first_fall");
    waitLevel(1'b1, "b2b_second_rise");
    checkOutput("b2b_done_before_second", 32'(done_count - d0), 32'(1));
    checkOutput("b2b_second_word", 32'(unsync_bus), 32'(8'h02));
    in_valid = 1'b0;
    waitDone("b2b_done");
    tick(3);
    checkOutput("b2b_total_done", 32'(done_count - d0), 32'(2));

    // Timeout with no acknowledge
    echo_mode  = 1'b0;
    forced_ack = 1'b0;
    d0 = done_count;
    applyStimulus(8'h5A);
    waitLevel(1'b1, "to_rise");
    in_valid = 1'b0;
    waitLevel(1'b0, "to_fall");
    checkOutput("to_err_set", 32'(timeout_err), 32'(1));
    tick(1);
    checkOutput("to_high_cycles", 32'(last_high), 32'(TIMEOUT));
    tick(3);
    checkOutput("to_no_done", 32'(done_count - d0), 32'(0));
    checkOutput("to_in_ready", 32'(in_ready), 32'(1));
    checkOutput("to_err_sticky", 32'(timeout_err), 32'(1));
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    checkOutput("to_err_cleared", 32'(timeout_err), 32'(0));

    // Timeout set wins over a simultaneous clear
    err_clr = 1'b1;
    applyStimulus(8'hA0);
    waitLevel(1'b1, "sw_rise");
    in_valid = 1'b0;
    waitLevel(1'b0, "sw_fall");
    checkOutput("sw_set_wins", 32'(timeout_err), 32'(1));
    tick(1);
    err_clr = 1'b0;
    checkOutput("sw_cleared_after", 32'(timeout_err), 32'(0));
    tick(2);

    // Ack arriving on the timeout cycle takes priority
    d0 = done_count;
    applyStimulus(8'h96);
    waitLevel(1'b1, "pri_rise");
    in_valid = 1'b0;
    tick(5);
    forced_ack = 1'b1;
    waitLevel(1'b0, "pri_fall");
    checkOutput("pri_no_err", 32'(timeout_err), 32'(0));
    forced_ack = 1'b0;
    waitDone("pri_done");
    checkOutput("pri_high_cycles", 32'(last_high), 32'(TIMEOUT));
    tick(3);
    checkOutput("pri_done_count", 32'(done_count - d0), 32'(1));

    // Stale acknowledge while idle blocks new words
    forced_ack = 1'b1;
    tick(3);
    checkOutput("stale_in_ready", 32'(in_ready), 32'(0));
    applyStimulus(8'h33);
    tick(4);
    checkOutput("stale_ignored", 32'(bus_enable), 32'(0));
    forced_ack = 1'b0;
    tick(1);
    checkOutput("stale_still_blocked", 32'(in_ready), 32'(0));
    tick(1);
    checkOutput("stale_ready_again", 32'(in_ready), 32'(1));
    checkOutput("stale_not_yet", 32'(bus_enable), 32'(0));
    tick(1);
    checkOutput("stale_accepted", 32'(bus_enable), 32'(1));
    in_valid  = 1'b0;
    echo_mode = 1'b1;
    waitDone("stale_done");
    tick(2);

    // Reset asserted mid-request
    echo_mode  = 1'b0;
    forced_ack = 1'b0;
    applyStimulus(8'h77);
    waitLevel(1'b1, "mr_rise");
    in_valid = 1'b0;
    tick(2);
    RST = 1'b0;
    #1;
    checkOutput("mr_bus_enable", 32'(bus_enable), 32'(0));
    checkOutput("mr_unsync_bus", 32'(unsync_bus), 32'(0));
    @(negedge CLK);
    RST = 1'b1;
    tick(2);
    checkOutput("mr_in_ready", 32'(in_ready), 32'(1));
    checkOutput("mr_idle", 32'(bus_enable), 32'(0));

    // Transfer after reset still works
    echo_mode = 1'b1;
    applyStimulus(8'hC3);
    waitLevel(1'b1, "post_rise");
    in_valid = 1'b0;
    waitDone("post_done");
    checkOutput("post_bus", 32'(unsync_bus), 32'(8'hC3));
    tick(2);

    checkOutput("sb_empty", 32'(sb_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
